// File: rtl/click_pkg.sv
// Shared types and sizing helpers for the click decoder.
package click_pkg;

    localparam int CLICKS_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } click_state_t;

    // Integer inputs make the product already exact, so the ceiling is the
    // product itself; clamp so a zero-length window still times out.
    function automatic int window_cycles(input int clk_mhz, input int window_us);
        int cycles;
        cycles = clk_mhz * window_us;
        return (cycles < 1) ? 1 : cycles;
    endfunction

endpackage

// File: rtl/click_event_fifo.sv
// Two-entry event FIFO; with CLICK_DECODER_DROP_CNT_EN it also counts pushes
// discarded while full.
module click_event_fifo
    import click_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                push_i,
    input  logic [CLICKS_W-1:0] push_data_i,
    input  logic                pop_i,
    output logic                valid_o,
    output logic [CLICKS_W-1:0] head_o
`ifdef CLICK_DECODER_DROP_CNT_EN
    ,
    output logic [15:0]         drop_cnt_o
`endif
);

    logic [CLICKS_W-1:0] mem_q [2];
    logic                rd_ptr_q;
    logic                wr_ptr_q;
    logic [1:0]          count_q;
    logic                full;
    logic                empty;
    logic                pop_en;
    logic                push_en;

    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);
    assign pop_en  = pop_i && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_en = push_i && (!full || pop_en);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_en) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_en) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign valid_o = !empty;
    assign head_o  = empty ? '0 : mem_q[rd_ptr_q];

`ifdef CLICK_DECODER_DROP_CNT_EN
    logic drop;

    assign drop = push_i && full && !pop_en;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            drop_cnt_o <= 16'h0000;
        end else if (drop && (drop_cnt_o != 16'hFFFF)) begin
            drop_cnt_o <= drop_cnt_o + 16'h0001;
        end
    end
`endif

endmodule

// File: rtl/click_decoder.sv
// Groups debounced press strobes into multi-click events and queues them.
// Optional drop counter port enabled by CLICK_DECODER_DROP_CNT_EN.
//
// state | meaning
// IDLE  | no sequence in progress, waiting for the first press
// COUNT | sequence open, counting presses inside the inter-click window
module click_decoder
    import click_pkg::*;
#(
    parameter int CLK_FREQ_MHZ    = 50,
    parameter int CLICK_WINDOW_US = 300,
    parameter int MAX_CLICKS      = 3
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                key_pressed_stb_i,
    output logic                event_valid_o,
    output logic [CLICKS_W-1:0] event_clicks_o,
    input  logic                event_ready_i
`ifdef CLICK_DECODER_DROP_CNT_EN
    ,
    output logic [15:0]         drop_cnt_o
`endif
);

    localparam int                  WINDOW_CYCLES = window_cycles(CLK_FREQ_MHZ, CLICK_WINDOW_US);
    localparam int                  TIMER_W       = $clog2(WINDOW_CYCLES) + 1;
    localparam logic [CLICKS_W-1:0] MAX_C         = CLICKS_W'(MAX_CLICKS);
    localparam logic [CLICKS_W-1:0] ONE_C         = CLICKS_W'(1);

    click_state_t        state_q, state_d;
    logic [CLICKS_W-1:0] clicks_q, clicks_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [CLICKS_W-1:0] clicks_inc;
    logic                timeout;
    logic                push;
    logic [CLICKS_W-1:0] push_data;
    logic                pop;

    assign clicks_inc = clicks_q + ONE_C;

    // The strobe cycle is the first cycle of the window, so the timer is
    // compared in its incremented form: a press at cycle s times out at s+W-1.
    assign timeout = (int'(timer_q) + 1) >= (WINDOW_CYCLES - 1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            clicks_q <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            clicks_q <= clicks_d;
            timer_q  <= timer_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clicks_d  = clicks_q;
        timer_d   = timer_q;
        push      = 1'b0;
        push_data = '0;
        unique case (state_q)
            IDLE: begin
                if (key_pressed_stb_i) begin
                    state_d  = COUNT;
                    clicks_d = ONE_C;
                    timer_d  = '0;
                end
            end
            COUNT: begin
                if (timeout && key_pressed_stb_i) begin
                    // Window closed this cycle: the press opens the next sequence.
                    push      = 1'b1;
                    push_data = clicks_q;
                    clicks_d  = ONE_C;
                    timer_d   = '0;
                end else if (timeout) begin
                    push      = 1'b1;
                    push_data = clicks_q;
                    state_d   = IDLE;
                    clicks_d  = '0;
                    timer_d   = '0;
                end else if (key_pressed_stb_i) begin
                    if (clicks_inc == MAX_C) begin
                        push      = 1'b1;
                        push_data = MAX_C;
                        state_d   = IDLE;
                        clicks_d  = '0;
                    end else begin
                        clicks_d = clicks_inc;
                    end
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop = event_valid_o && event_ready_i;

    click_event_fifo u_fifo (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .valid_o     (event_valid_o),
        .head_o      (event_clicks_o)
`ifdef CLICK_DECODER_DROP_CNT_EN
        ,
        .drop_cnt_o  (drop_cnt_o)
`endif
    );

endmodule

// File: doc/click_decoder.md
CLICK_DECODER -- requirements
Module: click_decoder

Interface
REQ-001 SHALL have parameter CLK_FREQ_MHZ, default 50: clock frequency in MHz.
REQ-002 SHALL have parameter CLICK_WINDOW_US, default 300: inter-click window in microseconds.
REQ-003 SHALL have parameter MAX_CLICKS, default 3: click count that closes a sequence immediately; legal range 2..15.
REQ-004 SHALL have port clk_i, input, 1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n_i, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port key_pressed_stb_i, input, 1: one-cycle debounced press strobe from the upstream debouncer.
REQ-007 SHALL have port event_valid_o, output, 1: a click event is presented.
REQ-008 SHALL have port event_clicks_o, output, 4: click count of the presented event, range 1..MAX_CLICKS.
REQ-009 SHALL have port event_ready_i, input, 1: the consumer accepts the event when event_valid_o is also high.
REQ-010 SHALL have port drop_cnt_o, output, 16: count of dropped events; present only with CLICK_DECODER_DROP_CNT_EN.

Function
REQ-011 SHALL compute WINDOW_CYCLES = ceil(CLK_FREQ_MHZ*CLICK_WINDOW_US), integer arithmetic, minimum 1.
REQ-012 SHALL implement FSM states IDLE and COUNT.
REQ-013 SHALL, in IDLE, on strobe: enter COUNT, set clicks=1, clear the window timer.
REQ-014 SHALL, in COUNT, increment the timer each cycle without a strobe.
REQ-015 SHALL, in COUNT, on strobe: clicks+1 and clear the timer.
REQ-016 SHALL, when clicks+1 equals MAX_CLICKS, push MAX_CLICKS and return to IDLE in that cycle.
REQ-017 SHALL, in COUNT, when timer == WINDOW_CYCLES-1 with no strobe: push clicks and return to IDLE.
REQ-018 SHALL, on a strobe in the timeout cycle: push the old count, clicks=1, timer=0, and remain in COUNT; the strobe starts a new sequence.
REQ-019 SHALL, because of REQ-018, never lose a strobe through a same-cycle timeout.
REQ-020 SHALL hold pushed events in a 2-entry FIFO.
REQ-021 SHALL drive event_valid_o = FIFO not empty, and event_clicks_o = FIFO head.
REQ-022 SHALL pop on event_valid_o && event_ready_i.
REQ-023 SHALL make a pushed event visible on event_valid_o the cycle after the push.
REQ-024 SHALL keep event_clicks_o stable while event_valid_o=1 and event_ready_i=0.
REQ-025 SHALL accept a push when the FIFO is full and a pop occurs in the same cycle.
REQ-026 SHALL discard a push when the FIFO is full and there is no pop; FIFO contents remain unchanged.
REQ-027 SHALL accept simultaneous push and pop at occupancy 1; occupancy stays 1.

Reset
REQ-028 SHALL, while rst_n_i=0: state=IDLE, clicks=0, timer=0, FIFO empty, event_valid_o=0, event_clicks_o=0, drop_cnt_o=0.
REQ-029 SHALL discard any sequence in progress when reset asserts mid-operation; no event is emitted for it after release.
REQ-030 SHALL accept a strobe in the first cycle after reset release.

Configuration
REQ-031 SHALL, with macro CLICK_DECODER_DROP_CNT_EN defined, add drop_cnt_o.
REQ-032 SHALL increment drop_cnt_o by 1 per discarded push (REQ-026), saturating at 16'hFFFF.
REQ-033 SHALL, without CLICK_DECODER_DROP_CNT_EN, omit the port and counter; all other behaviour is identical.

Structure
REQ-034 SHALL place in package click_pkg: the state enum typedef, CLICKS_W=4, and the WINDOW_CYCLES ceiling function.
REQ-035 SHALL implement the FIFO as sub-module click_event_fifo (depth 2, width CLICKS_W).
REQ-036 SHALL size the timer as $clog2(WINDOW_CYCLES)+1 bits.

Verification (CLK_FREQ_MHZ=1, CLICK_WINDOW_US=10, MAX_CLICKS=3, ready=1 unless stated)
REQ-037 SHALL cover: single strobe at cycle 0 -> push at cycle 9; event_valid_o=1 with clicks=1 at cycle 10 for one cycle.
REQ-038 SHALL cover: strobes at cycles 0 and 5 -> push at cycle 14; event clicks=2.
REQ-039 SHALL cover: strobes at cycles 0, 3, 6 -> immediate push at cycle 6; event clicks=3 visible at cycle 7; FSM in IDLE.
REQ-040 SHALL cover: strobe at cycle 0 and at the timeout cycle 9 -> event clicks=1, then a second event clicks=1 at cycle 19.
REQ-041 SHALL cover: ready=0 with three single-click sequences -> FIFO holds 2; third discarded; drop_cnt_o=1 with the macro; raising ready yields two events with clicks=1.
REQ-042 SHALL cover: rst_n_i pulsed low at cycle 4 after a strobe at cycle 0 -> no event is ever emitted; all outputs are 0 during reset.
